// File: rtl/sq_pkg.sv
// Shared constants for the square-wave front end and the SquareWave classifier:
// clock rate, counter width and half-period class thresholds in clocks.
package sq_pkg;

  localparam int unsigned CLK_HZ      = 30_000_000;
  localparam int unsigned SQ_CNT_W    = 17;
  localparam int unsigned SQ_FILT_LEN = 8;
  localparam int unsigned SQ_TIMEOUT  = 120_000;

  // Half-period class boundaries (0.2 ms / 1 ms / 2 ms).
  localparam int unsigned SQ_HALF_0P2MS_CLKS = CLK_HZ / 5_000;
  localparam int unsigned SQ_HALF_1MS_CLKS   = CLK_HZ / 1_000;
  localparam int unsigned SQ_HALF_2MS_CLKS   = CLK_HZ / 500;

  typedef struct packed {
    logic rise;
    logic fall;
  } sq_strobe_t;

endpackage

// File: rtl/sq_sync_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-cycle persistence filter.
// o_toggle is high in the cycle before o_clean takes its new value.
module sq_sync_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iRaw,
  output logic oClean,
  output logic oToggle
);

  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          clean_q, clean_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          toggle;

  always_comb begin
    s1_d    = iRaw;
    s2_d    = s1_q;
    clean_d = clean_q;
    fcnt_d  = '0;
    toggle  = 1'b0;
    // fcnt holds how many consecutive cycles s2 has already disagreed.
    if (s2_q != clean_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        toggle  = 1'b1;
        clean_d = ~clean_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oClean  = clean_q;
  assign oToggle = toggle;

endmodule

// File: rtl/square_wave_conditioner.sv
// Square-wave front end: clean level, edge strobes, half-period measurement
// and stuck-input detection on top of sq_sync_filter.
module square_wave_conditioner
  import sq_pkg::*;
#(
  parameter int unsigned FILT_LEN = SQ_FILT_LEN,
  parameter int unsigned CNT_W    = SQ_CNT_W,
  parameter int unsigned TIMEOUT  = SQ_TIMEOUT
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iSquareRaw,
  output logic             oSquareClean,
  output logic             oRise,
  output logic             oFall,
  output logic [CNT_W-1:0] oHalfPeriod,
  output logic             oHalfLevel,
  output logic             oHalfValid,
  output logic             oStuck
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             clean;
  logic             toggle;

  sq_strobe_t       strobe_q, strobe_d;
  logic             half_valid_q, half_valid_d;
  logic             half_level_q, half_level_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             armed_q, armed_d;
  logic             stuck_q, stuck_d;

  sq_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_filter (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iRaw    (iSquareRaw),
    .oClean  (clean),
    .oToggle (toggle)
  );

  // Everything keys off toggle so strobes line up with the new clean level.
  always_comb begin
    pcnt_d        = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
    strobe_d.rise = toggle & ~clean;
    strobe_d.fall = toggle & clean;
    half_valid_d  = toggle & armed_q;
    half_period_d = half_period_q;
    half_level_d  = half_level_q;
    armed_d       = armed_q;
    stuck_d       = stuck_q;
    if (toggle) begin
      pcnt_d  = CNT_W'(1);
      armed_d = 1'b1;
      stuck_d = 1'b0;
      if (armed_q) begin
        half_period_d = pcnt_q;
        half_level_d  = clean;
      end
    end else if (!armed_q || (pcnt_d == TIMEOUT_C)) begin
      stuck_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      strobe_q      <= '0;
      half_valid_q  <= 1'b0;
      half_level_q  <= 1'b0;
      half_period_q <= '0;
      pcnt_q        <= '0;
      armed_q       <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      strobe_q      <= strobe_d;
      half_valid_q  <= half_valid_d;
      half_level_q  <= half_level_d;
      half_period_q <= half_period_d;
      pcnt_q        <= pcnt_d;
      armed_q       <= armed_d;
      stuck_q       <= stuck_d;
    end
  end

  assign oSquareClean = clean;
  assign oRise        = strobe_q.rise;
  assign oFall        = strobe_q.fall;
  assign oHalfValid   = half_valid_q;
  assign oHalfLevel   = half_level_q;
  assign oHalfPeriod  = half_period_q;
  assign oStuck       = stuck_q;

endmodule

// File: tb/tb_square_wave_conditioner.sv
// Directed bench for square_wave_conditioner with time scaled down (CNT_W=10,
// TIMEOUT=600) so saturation and timeout are reached in a few thousand clocks.
`timescale 1ns/1ps
module tb_square_wave_conditioner;

  localparam int FILT_LEN = 8;
  localparam int CNT_W    = 10;
  localparam int TIMEOUT  = 600;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iSquareRaw = 1'b0;
  logic             oSquareClean;
  logic             oRise;
  logic             oFall;
  logic [CNT_W-1:0] oHalfPeriod;
  logic             oHalfLevel;
  logic             oHalfValid;
  logic             oStuck;

  square_wave_conditioner #(
    .FILT_LEN (FILT_LEN),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iSquareRaw   (iSquareRaw),
    .oSquareClean (oSquareClean),
    .oRise        (oRise),
    .oFall        (oFall),
    .oHalfPeriod  (oHalfPeriod),
    .oHalfLevel   (oHalfLevel),
    .oHalfValid   (oHalfValid),
    .oStuck       (oStuck)
  );

  // Clock / cycle counter
  always #16.67 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc++;

  // Scoreboard state: {level, period} of each completed half
  logic [CNT_W:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  logic prev_clean = 1'b0;
  bit   model_armed = 1'b0;
  int   last_edge_cyc = 0;
  logic raw_level = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // Drive a clean raw edge; the half it ends is queued once the model is armed.
  task automatic set_edge(input logic v);
    int d;
    d = cyc - last_edge_cyc;
    if (d > CNT_MAX) d = CNT_MAX;
    if (model_armed) exp_q.push_back({raw_level, CNT_W'(d)});
    model_armed   = 1'b1;
    last_edge_cyc = cyc;
    raw_level     = v;
    iSquareRaw    = v;
  endtask

  // Monitor: strobe shape and scoreboard pops
  always @(negedge iClk) begin : monitor
    logic [CNT_W:0] e;
    if (!iRst_n) begin
      prev_clean = 1'b0;
    end else begin
      check("rise_strobe", 32'(oRise), 32'(oSquareClean & ~prev_clean));
      check("fall_strobe", 32'(oFall), 32'(~oSquareClean & prev_clean));
      if (oRise) rise_cnt++;
      if (oFall) fall_cnt++;
      if (oHalfValid) begin
        check("half_valid_expected", 32'(exp_q.size() != 0), 32'd1);
        check("half_valid_with_strobe", 32'(oRise | oFall), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("half_period", 32'(oHalfPeriod), 32'(e[CNT_W-1:0]));
          check("half_level", 32'(oHalfLevel), 32'(e[CNT_W]));
        end
      end
      prev_clean = oSquareClean;
    end
  end

  initial begin
    int r0;
    int f0;
    bit v;

    // Reset values
    iRst_n = 1'b0;
    iSquareRaw = 1'b0;
    hold(3);
    check("rst_clean", 32'(oSquareClean), 32'd0);
    check("rst_rise", 32'(oRise), 32'd0);
    check("rst_fall", 32'(oFall), 32'd0);
    check("rst_valid", 32'(oHalfValid), 32'd0);
    check("rst_stuck", 32'(oStuck), 32'd0);
    check("rst_period", 32'(oHalfPeriod), 32'd0);
    check("rst_level", 32'(oHalfLevel), 32'd0);
    iRst_n = 1'b1;
    model_armed = 1'b0;
    hold(300);
    check("stuck_unarmed", 32'(oStuck), 32'd1);
    check("idle_clean", 32'(oSquareClean), 32'd0);

    // Test 1: first edge unarmed, then three measured halves
    set_edge(1'b1); hold(200);
    set_edge(1'b0); hold(100);
    set_edge(1'b1); hold(20);
    set_edge(1'b0); hold(50);
    check("t1_rises", 32'(rise_cnt), 32'd2);
    check("t1_falls", 32'(fall_cnt), 32'd2);
    check("t1_stuck_clear", 32'(oStuck), 32'd0);

    // Test 2: 5-clock high pulse on low level, 7-clock low gap on high level
    iSquareRaw = 1'b1; hold(5);
    iSquareRaw = 1'b0; hold(40);
    check("t2_pulse_clean", 32'(oSquareClean), 32'd0);
    check("t2_pulse_rises", 32'(rise_cnt), 32'd2);
    set_edge(1'b1); hold(60);
    iSquareRaw = 1'b0; hold(7);
    iSquareRaw = 1'b1; hold(40);
    check("t2_gap_clean", 32'(oSquareClean), 32'd1);
    check("t2_gap_falls", 32'(fall_cnt), 32'd2);
    check("t2_gap_rises", 32'(rise_cnt), 32'd3);

    // Test 3: single edge latency of 2+FILT_LEN clocks, 1-cycle strobe
    set_edge(1'b0);
    hold(9);
    check("t3_before_latency", 32'(oSquareClean), 32'd1);
    hold(1);
    check("t3_at_latency", 32'(oSquareClean), 32'd0);
    check("t3_fall_on", 32'(oFall), 32'd1);
    check("t3_valid_on", 32'(oHalfValid), 32'd1);
    hold(1);
    check("t3_fall_off", 32'(oFall), 32'd0);
    check("t3_valid_off", 32'(oHalfValid), 32'd0);

    // Test 4: stuck at TIMEOUT clocks after the clean edge, saturated report
    hold(608 - 11);
    check("t4_stuck_before", 32'(oStuck), 32'd0);
    hold(1);
    check("t4_stuck_at", 32'(oStuck), 32'd1);
    hold(700);
    check("t4_stuck_held", 32'(oStuck), 32'd1);
    set_edge(1'b1);
    hold(9);
    check("t4_stuck_pre_edge", 32'(oStuck), 32'd1);
    hold(1);
    check("t4_stuck_cleared", 32'(oStuck), 32'd0);
    check("t4_sat_valid", 32'(oHalfValid), 32'd1);
    check("t4_sat_period", 32'(oHalfPeriod), 32'(CNT_MAX));
    hold(90);

    // Test 5: reset in the middle of a high half with raw held high
    iRst_n = 1'b0;
    #1;
    check("t5_rst_clean", 32'(oSquareClean), 32'd0);
    check("t5_rst_stuck", 32'(oStuck), 32'd0);
    check("t5_rst_period", 32'(oHalfPeriod), 32'd0);
    check("t5_rst_level", 32'(oHalfLevel), 32'd0);
    hold(40);
    check("t5_rst_held_clean", 32'(oSquareClean), 32'd0);
    iRst_n = 1'b1;
    model_armed   = 1'b1;
    last_edge_cyc = cyc;
    raw_level     = 1'b1;
    hold(9);
    check("t5_before_rise", 32'(oSquareClean), 32'd0);
    hold(1);
    check("t5_rise_clean", 32'(oSquareClean), 32'd1);
    check("t5_rise_strobe", 32'(oRise), 32'd1);
    check("t5_rise_no_valid", 32'(oHalfValid), 32'd0);
    hold(140);
    set_edge(1'b0);
    hold(30);

    // Test 6: 1-clock bounce before every edge
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0);
      iSquareRaw = v;  hold(1);
      iSquareRaw = ~v; hold(1);
      set_edge(v);
      hold(120);
    end
    check("t6_rises", 32'(rise_cnt - r0), 32'd2);
    check("t6_falls", 32'(fall_cnt - f0), 32'd2);

    hold(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
